// File: rtl/mnist_pkg.sv
// Shared types and sizing helpers for the MNIST frame feeder.
package mnist_pkg;

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        WAIT_RES
    } feeder_state_t;

    localparam int FRAME_PIX = 784;

    function automatic int frame_pix(input int edge_len);
        return edge_len * edge_len;
    endfunction

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int min1_clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mnist_frame_feeder_frame_ram.sv
// Single-port frame store with a registered read port and write-first behaviour.
module frame_ram
    import mnist_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = FRAME_PIX,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  din,
    output logic [N-1:0]  dout
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mnist_frame_feeder.sv
// Buffers one host frame, replays it raster-order into the classifier and
// waits for the classifier's end-of-result pulse before taking the next frame.
module mnist_frame_feeder
    import mnist_pkg::*;
#(
    parameter int N          = 8,
    parameter int INPUT_SIZE = 28,
    parameter int GAP        = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] s_din,
    input  logic         s_vld,
    output logic         s_rdy,
    output logic [N-1:0] input_din,
    output logic         input_vld,
    input  logic         res_end,
    output logic         busy,
    output logic [15:0]  frame_cnt,
    output logic         err_timeout,
    output logic         err_unexp
);

    localparam int PIX = frame_pix(INPUT_SIZE);
    localparam int PW  = min1_clog2(PIX);
    localparam int GW  = min1_clog2(GAP + 1);
    localparam int TW  = min1_clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] LAST_PIX   = PW'(PIX - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    feeder_state_t state, next_state;

    logic [PW-1:0] wr_ptr, rd_ptr, ram_addr;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic [N-1:0]  ram_dout;
    logic          wr_en, rd_en, rd_pend;
    logic          res_ok, timed_out;

    assign s_rdy    = (state == LOAD) && !rst;
    assign busy     = (state != LOAD);
    assign ram_addr = (state == LOAD) ? wr_ptr : rd_ptr;

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        res_ok     = 1'b0;
        timed_out  = 1'b0;
        unique case (state)
            LOAD: begin
                wr_en = s_vld && s_rdy;
                if (wr_en && wr_ptr == LAST_PIX)
                    next_state = STREAM;
            end
            STREAM: begin
                rd_en = (gap_cnt == '0);
                if (rd_en && rd_ptr == LAST_PIX)
                    next_state = WAIT_RES;
            end
            WAIT_RES: begin
                // A result arriving on the timeout cycle still counts as a good frame.
                if (res_end) begin
                    res_ok     = 1'b1;
                    next_state = LOAD;
                end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
                    timed_out  = 1'b1;
                    next_state = LOAD;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            rd_pend     <= 1'b0;
            input_vld   <= 1'b0;
            input_din   <= '0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            err_unexp   <= 1'b0;
        end else begin
            state <= next_state;

            // RAM read data lands one cycle after the address; output register adds one more.
            rd_pend   <= rd_en;
            input_vld <= rd_pend;
            if (rd_pend)
                input_din <= ram_dout;

            if (wr_en)
                wr_ptr <= (wr_ptr == LAST_PIX) ? '0 : wr_ptr + PW'(1);

            if (state == STREAM) begin
                if (rd_en) begin
                    rd_ptr  <= (rd_ptr == LAST_PIX) ? '0 : rd_ptr + PW'(1);
                    gap_cnt <= GAP_RELOAD;
                end else begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
            end else begin
                rd_ptr  <= '0;
                gap_cnt <= '0;
            end

            to_cnt <= (state == WAIT_RES && next_state == WAIT_RES) ? to_cnt + TW'(1) : '0;

            if (res_ok)
                frame_cnt <= frame_cnt + 16'd1;
            if (timed_out)
                err_timeout <= 1'b1;
            if (res_end && state != WAIT_RES)
                err_unexp <= 1'b1;
        end
    end

    frame_ram #(
        .N    (N),
        .DEPTH(PIX),
        .AW   (PW)
    ) u_ram (
        .clk (clk),
        .we  (wr_en),
        .addr(ram_addr),
        .din (s_din),
        .dout(ram_dout)
    );

endmodule

// File: tb/tb_mnist_frame_feeder.sv
// Randomised bench for mnist_frame_feeder: a cycle-timed frame model plus directed
// literal checks on load/stream/result timing, timeouts, gaps and mid-frame reset.
module tb_mnist_frame_feeder;

    localparam int FP    = 784;
    localparam int M_GAP = 0;
    localparam int M_TO  = 64;
    localparam int P_LOAD   = 0;
    localparam int P_STREAM = 1;
    localparam int P_WAIT   = 2;

    logic        clk, rst, res_end;
    logic [7:0]  s_din;
    logic        s_vld, s_rdy;
    logic [7:0]  input_din;
    logic        input_vld, busy, err_timeout, err_unexp;
    logic [15:0] frame_cnt;

    logic [7:0]  g_sdin, g_din;
    logic        g_svld, g_rdy, g_vld, g_busy, g_eto, g_eux;
    logic [15:0] g_fcnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int host_mode = 0;
    int seq_idx   = 0;
    bit rdy_smp;
    int dut_pulses = 0;
    int dut_first  = -1;
    bit gap_done   = 0;

    int          m_phase = P_LOAD;
    int          m_load_idx, m_stream_start, m_wait_start, m_k;
    bit          m_stream_on, m_vld, m_err_to, m_err_ux;
    logic [7:0]  m_din;
    logic [15:0] m_frame_cnt;
    logic [7:0]  m_frame [FP];

    int g_cnt = 0, g_first = 0, g_last = 0, g_prev = 0, g_badp = 0, g_badd = 0, g_n = 0;
    int g_idx = 0;
    bit g_smp;

    mnist_frame_feeder #(.N(8), .INPUT_SIZE(28), .GAP(M_GAP), .TIMEOUT(M_TO)) u_dut (
        .clk(clk), .rst(rst), .s_din(s_din), .s_vld(s_vld), .s_rdy(s_rdy),
        .input_din(input_din), .input_vld(input_vld), .res_end(res_end), .busy(busy),
        .frame_cnt(frame_cnt), .err_timeout(err_timeout), .err_unexp(err_unexp)
    );

    mnist_frame_feeder #(.N(8), .INPUT_SIZE(28), .GAP(3), .TIMEOUT(64)) u_gap (
        .clk(clk), .rst(rst), .s_din(g_sdin), .s_vld(g_svld), .s_rdy(g_rdy),
        .input_din(g_din), .input_vld(g_vld), .res_end(1'b0), .busy(g_busy),
        .frame_cnt(g_fcnt), .err_timeout(g_eto), .err_unexp(g_eux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit re);
        rst     = r;
        res_end = re;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic waitPhase(input int ph, input int budget, input string what);
        int n;
        n = 0;
        while (m_phase != ph && n < budget) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        if (m_phase != ph) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_%s: still in phase %0d after %0d cycles, required %0d", what, m_phase, n, ph);
        end
    endtask

    // Frame model: everything is timed from the edge that accepted the last byte.
    always @(posedge clk) begin
        cyc++;
        m_vld = 1'b0;
        if (rst) begin
            m_phase     = P_LOAD;
            m_load_idx  = 0;
            m_stream_on = 1'b0;
            m_frame_cnt = '0;
            m_err_to    = 1'b0;
            m_err_ux    = 1'b0;
            m_din       = '0;
        end else begin
            if (res_end && m_phase != P_WAIT) m_err_ux = 1'b1;
            case (m_phase)
                P_LOAD: if (s_vld) begin
                    m_frame[m_load_idx] = s_din;
                    if (m_load_idx == FP - 1) begin
                        m_load_idx     = 0;
                        m_phase        = P_STREAM;
                        m_stream_start = cyc;
                        m_stream_on    = 1'b1;
                    end else begin
                        m_load_idx++;
                    end
                end
                P_STREAM: if (cyc == m_stream_start + 1 + (FP - 1) * (M_GAP + 1)) begin
                    m_phase      = P_WAIT;
                    m_wait_start = cyc;
                end
                default: begin
                    if (res_end) begin
                        m_frame_cnt++;
                        m_phase = P_LOAD;
                    end else if (M_TO != 0 && cyc - m_wait_start == M_TO) begin
                        m_err_to = 1'b1;
                        m_phase  = P_LOAD;
                    end
                end
            endcase
            if (m_stream_on) begin
                m_k = cyc - m_stream_start - 2;
                if (m_k >= 0 && m_k % (M_GAP + 1) == 0 && m_k / (M_GAP + 1) < FP) begin
                    m_vld = 1'b1;
                    m_din = m_frame[m_k / (M_GAP + 1)];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            checkOutput("s_rdy", s_rdy, (m_phase == P_LOAD) && !rst);
            checkOutput("input_vld", input_vld, m_vld);
            checkOutput("input_din", input_din, m_din);
            checkOutput("busy", busy, m_phase != P_LOAD);
            checkOutput("frame_cnt", frame_cnt, m_frame_cnt);
            checkOutput("err_timeout", err_timeout, m_err_to);
            checkOutput("err_unexp", err_unexp, m_err_ux);
            if (input_vld === 1'b1) begin
                dut_pulses++;
                if (dut_first < 0) dut_first = cyc;
            end
        end
    end

    // Host for the main instance: holds a refused byte, otherwise follows host_mode.
    initial begin
        s_vld = 1'b0;
        s_din = '0;
        forever begin
            @(negedge clk);
            rdy_smp = s_rdy;
            @(posedge clk);
            #2;
            if (s_vld && rdy_smp) seq_idx++;
            if (!(s_vld && !rdy_smp)) begin
                case (host_mode)
                    1: begin s_vld = 1'b1; s_din = seq_idx[7:0]; end
                    2: begin s_vld = ($urandom_range(0, 3) != 0); s_din = 8'($urandom); end
                    default: s_vld = 1'b0;
                endcase
            end
        end
    end

    // Host for the GAP=3 instance: one frame of bytes 0..783, then quiet.
    initial begin
        g_svld = 1'b1;
        g_sdin = '0;
        while (g_idx < FP) begin
            @(negedge clk);
            g_smp = g_rdy;
            @(posedge clk);
            #2;
            if (g_smp) begin
                g_idx++;
                if (g_idx == FP) g_svld = 1'b0;
                else g_sdin = g_idx[7:0];
            end
        end
    end

    initial begin
        while (g_cnt < FP && g_n < 8000) begin
            @(posedge clk);
            #1;
            g_n++;
            if (g_vld === 1'b1) begin
                if (g_cnt == 0) g_first = cyc;
                else if (cyc - g_prev != 4) g_badp++;
                if (g_din !== 8'(g_cnt)) g_badd++;
                g_prev = cyc;
                g_last = cyc;
                g_cnt++;
            end
        end
        checkOutput("gap_pulses", g_cnt, FP);
        // Measured from the first pulse to the end of the final pixel's gap slot.
        checkOutput("gap_span", g_last - g_first + 3, 3135);
        checkOutput("gap_period_errs", g_badp, 0);
        checkOutput("gap_data_errs", g_badd, 0);
        gap_done = 1'b1;
    end

    initial begin
        int n, d;
        rst       = 1'b1;
        res_end   = 1'b0;
        host_mode = 1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_s_rdy", s_rdy, 0);
        checkOutput("reset_vld", input_vld, 0);
        checkOutput("reset_din", input_din, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_cnt", frame_cnt, 0);
        checkOutput("reset_errs", {err_timeout, err_unexp}, 0);

        // Sequential frame, bytes 0..783 with s_vld held high.
        waitPhase(P_STREAM, 6000, "f1_stream");
        checkOutput("f1_rdy_low_after_load", s_rdy, 0);
        dut_pulses = 0;
        dut_first  = -1;
        waitPhase(P_WAIT, 6000, "f1_wait");
        idle(10);
        checkOutput("f1_pulses", dut_pulses, FP);
        checkOutput("f1_first_latency", dut_first - m_stream_start, 2);
        checkOutput("f1_last_pixel", input_din, 783 % 256);
        applyStimulus(1'b0, 1'b1);
        checkOutput("f1_frame_cnt", frame_cnt, 1);
        checkOutput("f1_rdy_after_res", s_rdy, 1);
        checkOutput("f1_errs", {err_timeout, err_unexp}, 0);

        // Random frame: stray result mid-stream, then a result on the timeout cycle.
        host_mode = 2;
        waitPhase(P_STREAM, 6000, "f2_stream");
        dut_pulses = 0;
        idle(300);
        applyStimulus(1'b0, 1'b1);
        checkOutput("f2_err_unexp", err_unexp, 1);
        waitPhase(P_WAIT, 6000, "f2_wait");
        idle(63);
        applyStimulus(1'b0, 1'b1);
        checkOutput("f2_frame_cnt", frame_cnt, 2);
        checkOutput("f2_err_timeout", err_timeout, 0);
        checkOutput("f2_busy", busy, 0);
        idle(1);
        checkOutput("f2_pulses", dut_pulses, FP);

        // No result: timeout exactly 64 cycles after WAIT_RES entry.
        waitPhase(P_STREAM, 6000, "f3_stream");
        waitPhase(P_WAIT, 6000, "f3_wait");
        idle(63);
        checkOutput("f3_no_timeout_yet", err_timeout, 0);
        checkOutput("f3_busy_before", busy, 1);
        idle(1);
        checkOutput("f3_err_timeout", err_timeout, 1);
        checkOutput("f3_busy_after", busy, 0);
        checkOutput("f3_frame_cnt", frame_cnt, 2);

        // Reset while pixel 400 is on the stream output.
        n = 0;
        while (!gap_done && n < 10000) begin
            idle(1);
            n++;
        end
        waitPhase(P_STREAM, 6000, "f4_stream");
        idle(402);
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_vld", input_vld, 0);
        checkOutput("rst_mid_s_rdy", s_rdy, 1);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_frame_cnt", frame_cnt, 0);
        checkOutput("rst_mid_errs", {err_timeout, err_unexp}, 0);

        // Random frames with random result delay, some past the timeout.
        for (int f = 0; f < 4; f++) begin
            waitPhase(P_STREAM, 6000, "rnd_stream");
            dut_pulses = 0;
            dut_first  = -1;
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 700));
                applyStimulus(1'b0, 1'b1);
            end
            waitPhase(P_WAIT, 6000, "rnd_wait");
            d = $urandom_range(0, 80);
            n = 0;
            while (n < d && m_phase == P_WAIT) begin
                idle(1);
                n++;
            end
            if (m_phase == P_WAIT) applyStimulus(1'b0, 1'b1);
            idle(2);
            checkOutput("rnd_pulses", dut_pulses, FP);
            checkOutput("rnd_first_latency", dut_first - m_stream_start, 2);
        end

        idle(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
